// File: rtl/IO_DebouncePkg.sv
// Shared types and constants for the key debouncer.
package IO_DebouncePkg;

    // Per-channel debounce state: waiting for a change, or timing a candidate level.
    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } DebounceState_t;

    // Key pins idle high; a pressed key pulls its pin low.
    localparam logic KEY_RELEASED_LEVEL = 1'b1;

    // 10 ms of stability at the 15 MHz I/O clock.
    localparam int unsigned DEFAULT_STABLE_COUNT = 150000;

endpackage

// File: rtl/debounce_channel.sv
// One key: two-flop synchroniser, stability timer and registered clean/strobe outputs.
module debounce_channel
    import IO_DebouncePkg::*;
#(
    parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter int unsigned CNT_WIDTH    = $clog2(STABLE_COUNT)
) (
    input  logic Clock,
    input  logic Reset,
    input  logic KeyRaw,
    output logic KeyClean,
    output logic KeyPressed,
    output logic KeyReleased
);

    // Last count value before the new level is accepted; the counter never exceeds it.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic                 sync_q1;
    logic                 key_sync;
    DebounceState_t       state;
    DebounceState_t       state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 clean_nxt;
    logic                 pressed_nxt;
    logic                 released_nxt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync_q1  <= KEY_RELEASED_LEVEL;
            key_sync <= KEY_RELEASED_LEVEL;
        end else begin
            sync_q1  <= KeyRaw;
            key_sync <= sync_q1;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= DB_IDLE;
            cnt         <= '0;
            KeyClean    <= KEY_RELEASED_LEVEL;
            KeyPressed  <= 1'b0;
            KeyReleased <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            KeyClean    <= clean_nxt;
            KeyPressed  <= pressed_nxt;
            KeyReleased <= released_nxt;
        end
    end

    // Next-state: time how long the synchronised level differs from the clean level.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        clean_nxt    = KeyClean;
        pressed_nxt  = 1'b0;
        released_nxt = 1'b0;
        case (state)
            DB_IDLE: begin
                cnt_nxt = '0;
                if (key_sync != KeyClean) begin
                    state_nxt = DB_COUNT;
                    cnt_nxt   = CNT_WIDTH'(1);
                end
            end
            DB_COUNT: begin
                if (key_sync == KeyClean) begin
                    // Bounced back before the stability window elapsed.
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt    = DB_IDLE;
                    cnt_nxt      = '0;
                    clean_nxt    = key_sync;
                    pressed_nxt  = ~key_sync;
                    released_nxt = key_sync;
                end else begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = DB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_debouncer.sv
// Array of independent key debounce channels feeding the key & display unit.
module key_debouncer
    import IO_DebouncePkg::*;
#(
    parameter int unsigned NUM_KEYS     = 4,
    parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] KeysRaw,
    output logic [NUM_KEYS-1:0] KeysClean,
    output logic [NUM_KEYS-1:0] KeysPressed,
    output logic [NUM_KEYS-1:0] KeysReleased
);

    localparam int unsigned CNT_WIDTH = $clog2(STABLE_COUNT);

    // A window shorter than two cycles leaves no room for the counter to run.
    if (STABLE_COUNT < 2) begin : g_bad_stable_count
        $error("key_debouncer: STABLE_COUNT must be at least 2");
    end

    // One channel per key; channels share nothing but the clock and reset.
    for (genvar k = 0; k < int'(NUM_KEYS); k++) begin : g_key
        debounce_channel #(
            .STABLE_COUNT (STABLE_COUNT),
            .CNT_WIDTH    (CNT_WIDTH)
        ) u_channel (
            .Clock       (Clock),
            .Reset       (Reset),
            .KeyRaw      (KeysRaw[k]),
            .KeyClean    (KeysClean[k]),
            .KeyPressed  (KeysPressed[k]),
            .KeyReleased (KeysReleased[k])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with a short stability window of 8 cycles.
module tb_key_debouncer;

    localparam int unsigned NK  = 4;
    localparam int unsigned SC  = 8;
    localparam int          LAT = 10;

    logic          Clock   = 1'b0;
    logic          Reset   = 1'b0;
    logic [NK-1:0] KeysRaw = 4'h0;
    logic [NK-1:0] KeysClean;
    logic [NK-1:0] KeysPressed;
    logic [NK-1:0] KeysReleased;

    int n_cmp = 0;
    int n_bad = 0;

    key_debouncer #(
        .NUM_KEYS     (NK),
        .STABLE_COUNT (SC)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .KeysRaw      (KeysRaw),
        .KeysClean    (KeysClean),
        .KeysPressed  (KeysPressed),
        .KeysReleased (KeysReleased)
    );

    always #5 Clock = ~Clock;

    // Observe a fixed number of cycles at falling edges; cycle i reflects rising edge i.
    task automatic watch(input int cycles,
                         output int chg_at, output int press_at, output int press_cyc,
                         output logic [NK-1:0] press_or,
                         output int rel_at, output int rel_cyc,
                         output logic [NK-1:0] rel_or, output logic both);
        logic [NK-1:0] start;
        start = KeysClean;
        chg_at = 0; press_at = 0; press_cyc = 0; press_or = '0;
        rel_at = 0; rel_cyc = 0; rel_or = '0; both = 1'b0;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge Clock);
            if (chg_at == 0 && KeysClean !== start) chg_at = i;
            if (KeysPressed != '0) begin
                if (press_at == 0) press_at = i;
                press_cyc++;
                press_or |= KeysPressed;
            end
            if (KeysReleased != '0) begin
                if (rel_at == 0) rel_at = i;
                rel_cyc++;
                rel_or |= KeysReleased;
            end
            if ((KeysPressed & KeysReleased) != '0) both = 1'b1;
        end
    endtask

    task automatic test_reset();
        int c, pa, pc, ra, rc; logic [NK-1:0] po, ro; logic b;
        KeysRaw = 4'h0;
        repeat (3) @(negedge Clock);
        n_cmp++; if (KeysClean !== 4'hF) begin n_bad++; $display("FAIL reset_clean got=%h want=%h", KeysClean, 4'hF); end
        n_cmp++; if (KeysPressed !== 4'h0) begin n_bad++; $display("FAIL reset_pressed got=%h want=%h", KeysPressed, 4'h0); end
        n_cmp++; if (KeysReleased !== 4'h0) begin n_bad++; $display("FAIL reset_released got=%h want=%h", KeysReleased, 4'h0); end
        Reset = 1'b1;
        watch(15, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (c !== LAT) begin n_bad++; $display("FAIL reset_latency got=%0d want=%0d", c, LAT); end
        n_cmp++; if (pa !== LAT) begin n_bad++; $display("FAIL reset_press_at got=%0d want=%0d", pa, LAT); end
        n_cmp++; if (pc !== 1) begin n_bad++; $display("FAIL reset_press_cycles got=%0d want=1", pc); end
        n_cmp++; if (po !== 4'hF) begin n_bad++; $display("FAIL reset_press_bits got=%h want=%h", po, 4'hF); end
        n_cmp++; if (KeysClean !== 4'h0) begin n_bad++; $display("FAIL reset_clean_after got=%h want=%h", KeysClean, 4'h0); end
        // Return all keys to released.
        KeysRaw = 4'hF;
        watch(15, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (ro !== 4'hF || ra !== LAT || rc !== 1) begin n_bad++; $display("FAIL reset_release_all got=%h@%0d x%0d want=%h@%0d x1", ro, ra, rc, 4'hF, LAT); end
    endtask

    task automatic test_press_release();
        int c, pa, pc, ra, rc; logic [NK-1:0] po, ro; logic b;
        KeysRaw = 4'hD;
        watch(20, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (c !== LAT) begin n_bad++; $display("FAIL press1_latency got=%0d want=%0d", c, LAT); end
        n_cmp++; if (po !== 4'h2 || pc !== 1 || pa !== LAT) begin n_bad++; $display("FAIL press1_strobe got=%h@%0d x%0d want=%h@%0d x1", po, pa, pc, 4'h2, LAT); end
        n_cmp++; if (ro !== 4'h0) begin n_bad++; $display("FAIL press1_no_release got=%h want=%h", ro, 4'h0); end
        n_cmp++; if (KeysClean !== 4'hD) begin n_bad++; $display("FAIL press1_clean got=%h want=%h", KeysClean, 4'hD); end
        KeysRaw = 4'hF;
        watch(15, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (ro !== 4'h2 || rc !== 1 || ra !== LAT) begin n_bad++; $display("FAIL release1_strobe got=%h@%0d x%0d want=%h@%0d x1", ro, ra, rc, 4'h2, LAT); end
        n_cmp++; if (po !== 4'h0) begin n_bad++; $display("FAIL release1_no_press got=%h want=%h", po, 4'h0); end
        n_cmp++; if (KeysClean !== 4'hF) begin n_bad++; $display("FAIL release1_clean got=%h want=%h", KeysClean, 4'hF); end
    endtask

    task automatic test_bounce();
        int c, pa, pc, ra, rc; logic [NK-1:0] po, ro; logic b;
        int any_chg; logic [NK-1:0] any_strobe;
        any_chg = 0; any_strobe = '0;
        for (int r = 0; r < 5; r++) begin
            KeysRaw = 4'hB;
            watch(7, c, pa, pc, po, ra, rc, ro, b);
            any_chg += c; any_strobe |= po | ro;
            KeysRaw = 4'hF;
            watch(1, c, pa, pc, po, ra, rc, ro, b);
            any_chg += c; any_strobe |= po | ro;
        end
        n_cmp++; if (any_chg !== 0 || KeysClean !== 4'hF) begin n_bad++; $display("FAIL bounce_clean got=%h chg=%0d want=%h chg=0", KeysClean, any_chg, 4'hF); end
        n_cmp++; if (any_strobe !== 4'h0) begin n_bad++; $display("FAIL bounce_strobe got=%h want=%h", any_strobe, 4'h0); end
        KeysRaw = 4'hB;
        watch(15, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (c !== LAT || po !== 4'h4 || pc !== 1) begin n_bad++; $display("FAIL bounce_final_press got=%h@%0d x%0d want=%h@%0d x1", po, c, pc, 4'h4, LAT); end
        KeysRaw = 4'hF;
        watch(15, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (KeysClean !== 4'hF || ro !== 4'h4) begin n_bad++; $display("FAIL bounce_restore got=%h/%h want=%h/%h", KeysClean, ro, 4'hF, 4'h4); end
    endtask

    task automatic test_threshold();
        int c, pa, pc, ra, rc; logic [NK-1:0] po, ro; logic b;
        // Seven cycles low: one short of the window.
        KeysRaw = 4'hE;
        watch(7, c, pa, pc, po, ra, rc, ro, b);
        KeysRaw = 4'hF;
        watch(15, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (KeysClean !== 4'hF || po !== 4'h0 || ro !== 4'h0) begin n_bad++; $display("FAIL thresh7_ignored got=%h p=%h r=%h want=%h p=0 r=0", KeysClean, po, ro, 4'hF); end
        // Eight cycles low: exactly the window.
        KeysRaw = 4'hE;
        watch(8, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (c !== 0 || po !== 4'h0) begin n_bad++; $display("FAIL thresh8_early got chg=%0d p=%h want chg=0 p=0", c, po); end
        KeysRaw = 4'hF;
        watch(20, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (c !== 2 || pa !== 2 || pc !== 1 || po !== 4'h1) begin n_bad++; $display("FAIL thresh8_press got=%h@%0d x%0d chg=%0d want=%h@2 x1 chg=2", po, pa, pc, c, 4'h1); end
        n_cmp++; if (ra !== LAT || rc !== 1 || ro !== 4'h1) begin n_bad++; $display("FAIL thresh8_release got=%h@%0d x%0d want=%h@%0d x1", ro, ra, rc, 4'h1, LAT); end
        n_cmp++; if (KeysClean !== 4'hF) begin n_bad++; $display("FAIL thresh8_clean_end got=%h want=%h", KeysClean, 4'hF); end
    endtask

    task automatic test_simultaneous();
        int c, pa, pc, ra, rc; logic [NK-1:0] po, ro; logic b;
        KeysRaw = 4'h5;
        watch(15, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (c !== LAT || pa !== LAT || po !== 4'hA || pc !== 1) begin n_bad++; $display("FAIL simul_press got=%h@%0d x%0d chg=%0d want=%h@%0d x1", po, pa, pc, c, 4'hA, LAT); end
        n_cmp++; if (ro !== 4'h0) begin n_bad++; $display("FAIL simul_no_release got=%h want=%h", ro, 4'h0); end
        n_cmp++; if (KeysClean !== 4'h5) begin n_bad++; $display("FAIL simul_clean got=%h want=%h", KeysClean, 4'h5); end
        KeysRaw = 4'hF;
        watch(15, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (ro !== 4'hA || ra !== LAT || b !== 1'b0) begin n_bad++; $display("FAIL simul_release got=%h@%0d both=%b want=%h@%0d both=0", ro, ra, b, 4'hA, LAT); end
    endtask

    task automatic test_reset_mid_count();
        int c, pa, pc, ra, rc; logic [NK-1:0] po, ro; logic b;
        KeysRaw = 4'h7;
        // Counter holds 5 after the seventh edge.
        watch(7, c, pa, pc, po, ra, rc, ro, b);
        Reset = 1'b0;
        #1;
        n_cmp++; if (KeysClean !== 4'hF || KeysPressed !== 4'h0) begin n_bad++; $display("FAIL midcount_reset got=%h p=%h want=%h p=0", KeysClean, KeysPressed, 4'hF); end
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        watch(15, c, pa, pc, po, ra, rc, ro, b);
        n_cmp++; if (c !== LAT || po !== 4'h8 || pc !== 1) begin n_bad++; $display("FAIL midcount_full_latency got=%h@%0d x%0d want=%h@%0d x1", po, c, pc, 4'h8, LAT); end
        // Asynchronous reset of an accepted press, away from any clock edge.
        #2;
        Reset = 1'b0;
        #1;
        n_cmp++; if (KeysClean !== 4'hF) begin n_bad++; $display("FAIL async_reset_clean got=%h want=%h", KeysClean, 4'hF); end
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_threshold();
        test_simultaneous();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
